mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the fetch-stage instruction port and the memory-stage data port of the pipelined core.
- Sequences each access with a fixed-latency handshake and reports per-port stall signals to the hazard unit.
- Data port has priority over fetch. A streak counter guarantees fetch is not starved.

Parameters:
DATA_WIDTH, 32, width of data words
ADDRESS_WIDTH, 32, width of byte addresses
LATENCY, 2, memory read latency in cycles (>=1)
MAX_STREAK, 4, maximum consecutive data grants allowed while fetch is waiting (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held until if_ack
if_addr  input  ADDRESS_WIDTH  fetch address
if_ack  output  1  one-cycle pulse: fetch read complete
if_rdata  output  DATA_WIDTH  fetched instruction word
if_stall  output  1  if_req & ~if_ack
dm_req  input  1  data request; held until dm_ack
dm_we  input  1  1 = write, 0 = read
dm_addr  input  ADDRESS_WIDTH  data address
dm_wdata  input  DATA_WIDTH  write data
dm_ack  output  1  one-cycle pulse: data access complete
dm_rdata  output  DATA_WIDTH  load data
dm_stall  output  1  dm_req & ~dm_ack
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  memory write enable
mem_addr  output  ADDRESS_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid LATENCY cycles after the mem_en cycle

Behaviour:
- Reset values:
  - state IDLE; wait counter 0; streak 0; grant register 0.
  - if_ack, dm_ack, mem_en and mem_we are 0.
  - if_rdata and dm_rdata are 0.
- States: IDLE, WAIT.
- IDLE, grant selection (combinational from the requests and the streak):
  - Only dm_req: data is granted.
  - Only if_req: fetch is granted.
  - Both asserted, streak < MAX_STREAK: data is granted.
  - Both asserted, streak == MAX_STREAK: fetch is granted.
- IDLE, issue cycle (any request present):
  - mem_en=1.
  - mem_addr, mem_we and mem_wdata are muxed from the granted port.
  - mem_we = dm_we only when data is granted, else 0.
  - The grant is latched and the next state is WAIT.
  - Wait counter is loaded with LATENCY-1 for a read, 0 for a write.
- IDLE with no request: mem_en=0. mem_addr and mem_wdata are don't-care but held at the last value.
- WAIT:
  - mem_en=0.
  - Counter decrements each cycle.
  - In the cycle the counter is 0, the granted port's ack is 1 and the next state is IDLE.
- Latency:
  - Read issued in cycle T is acked in cycle T+LATENCY.
  - Write issued in cycle T is acked in T+1.
  - IDLE always separates two accesses. Peak throughput is one read per LATENCY+1 cycles and one write per 2 cycles.
- Read data:
  - In the ack cycle, the port's rdata equals mem_rdata combinationally, and mem_rdata is captured at that clock edge.
  - Afterwards rdata holds the captured value until that port's next read ack.
  - Writes leave dm_rdata unchanged.
- Streak counter, updated only at issue:
  - Data grant while if_req=1: streak+1, saturating at MAX_STREAK.
  - Data grant while if_req=0: streak=0.
  - Fetch grant: streak=0.
- Stall outputs are combinational and asserted in every cycle from the request until the ack, including the issue cycle. The hazard unit freezes the corresponding pipeline stage on them.
- Request deasserted while in WAIT: this is a protocol violation. The arbiter still completes the access and pulses the ack.
- Reset mid-access:
  - Synchronous rst returns to IDLE and no ack is produced for the abandoned access.
  - Memory output returned afterwards is ignored.
- No combinational path from mem_rdata to any control output.

Test Plan:
- Single fetch read (LATENCY=2), if_addr=0x10, mem returns 0x00500093:
  - mem_en=1 at T.
  - if_ack=1 and if_rdata=0x00500093 at T+2.
  - if_stall high T..T+1, low at T+2.
- Data write: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF:
  - At T: mem_en=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF.
  - dm_ack at T+1.
  - dm_rdata unchanged.
- Simultaneous if_req and dm_req (read) from reset: data is issued first, dm_ack at T+2, then fetch is issued at T+3.
- Starvation bound (MAX_STREAK=4): if_req held while dm_req is reissued continuously.
  - Exactly 4 data grants occur, then the 5th grant is fetch.
  - Streak is 0 after the fetch grant.
- Reset at T+1 during a fetch read: no if_ack at T+2, state IDLE, if_rdata=0, next request issued normally.
- LATENCY=1 back-to-back fetch reads 0x0 and 0x4: mem_en at T and T+2, if_ack at T+1 and T+3, each carrying the correct word.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port memory between fetch and data accesses.
// Data has priority; a saturating streak counter forces a fetch grant after MAX_STREAK data wins.
module mem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int LATENCY       = 2,
    parameter int MAX_STREAK    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic                     if_ack,
    output logic [DATA_WIDTH-1:0]    if_rdata,
    output logic                     if_stall,
    input  logic                     dm_req,
    input  logic                     dm_we,
    input  logic [ADDRESS_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0]    dm_wdata,
    output logic                     dm_ack,
    output logic [DATA_WIDTH-1:0]    dm_rdata,
    output logic                     dm_stall,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SW = $clog2(MAX_STREAK + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                   state, state_next;
    logic [CW-1:0]            cnt, cnt_next;
    logic [SW-1:0]            streak, streak_next;
    logic                     grant_dm, grant_dm_next;
    logic                     we_q, we_next;
    logic                     issue, sel_dm;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    if_rdata_q, dm_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            streak     <= '0;
            grant_dm   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            streak   <= streak_next;
            grant_dm <= grant_dm_next;
            we_q     <= we_next;
            if (issue) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (if_ack)
                if_rdata_q <= mem_rdata;
            if (dm_ack && !we_q)
                dm_rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        streak_next   = streak;
        grant_dm_next = grant_dm;
        we_next       = we_q;
        issue         = 1'b0;
        sel_dm        = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = addr_q;
        mem_wdata     = wdata_q;
        if_ack        = 1'b0;
        dm_ack        = 1'b0;

        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    issue         = 1'b1;
                    sel_dm        = dm_req && (!if_req || (streak < SW'(MAX_STREAK)));
                    mem_en        = 1'b1;
                    mem_we        = sel_dm && dm_we;
                    mem_addr      = sel_dm ? dm_addr : if_addr;
                    mem_wdata     = sel_dm ? dm_wdata : wdata_q;
                    grant_dm_next = sel_dm;
                    we_next       = mem_we;
                    cnt_next      = mem_we ? '0 : CW'(LATENCY - 1);
                    if (!sel_dm || !if_req)
                        streak_next = '0;
                    else if (streak != SW'(MAX_STREAK))
                        streak_next = streak + 1'b1;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    if_ack     = !grant_dm;
                    dm_ack     = grant_dm;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // strobes stay quiet in a reset cycle so the abandoned access cannot ack
        if (rst) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
            if_ack = 1'b0;
            dm_ack = 1'b0;
        end
    end

    assign if_rdata = if_ack ? mem_rdata : if_rdata_q;
    assign dm_rdata = (dm_ack && !we_q) ? mem_rdata : dm_rdata_q;
    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at LATENCY=2, one at LATENCY=1,
// each with a small behavioural memory delaying read data by LATENCY cycles.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        if_req_a = 1'b0, dm_req_a = 1'b0, dm_we_a = 1'b0;
    logic [31:0] if_addr_a = '0, dm_addr_a = '0, dm_wdata_a = '0;
    logic        if_ack_a, if_stall_a, dm_ack_a, dm_stall_a, mem_en_a, mem_we_a;
    logic [31:0] if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;

    logic        if_req_b = 1'b0, dm_req_b = 1'b0, dm_we_b = 1'b0;
    logic [31:0] if_addr_b = '0, dm_addr_b = '0, dm_wdata_b = '0;
    logic        if_ack_b, if_stall_b, dm_ack_b, dm_stall_b, mem_en_b, mem_we_b;
    logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .LATENCY(2), .MAX_STREAK(4)) u_a (
        .clk(clk), .rst(rst),
        .if_req(if_req_a), .if_addr(if_addr_a), .if_ack(if_ack_a), .if_rdata(if_rdata_a), .if_stall(if_stall_a),
        .dm_req(dm_req_a), .dm_we(dm_we_a), .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a),
        .dm_ack(dm_ack_a), .dm_rdata(dm_rdata_a), .dm_stall(dm_stall_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata_a)
    );

    mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .LATENCY(1), .MAX_STREAK(4)) u_b (
        .clk(clk), .rst(rst),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b), .if_stall(if_stall_b),
        .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
        .dm_ack(dm_ack_b), .dm_rdata(dm_rdata_b), .dm_stall(dm_stall_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b)
    );

    // memory contents: fixed pattern plus one writable slot
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr  = '0;
    logic [31:0] wr_data  = '0;
    logic [31:0] s1_a = '0, s2_a = '0, s1_b = '0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (wr_valid && a == wr_addr) return wr_data;
        if (a == 32'h10) return 32'h0050_0093;
        return 32'h1000_0000 + a;
    endfunction

    always @(posedge clk) begin
        if (mem_en_a && mem_we_a) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr_a;
            wr_data  <= mem_wdata_a;
        end
        s1_a <= rd_word(mem_addr_a);
        s2_a <= s1_a;
        s1_b <= rd_word(mem_addr_b);
    end
    assign mem_rdata_a = s2_a;
    assign mem_rdata_b = s1_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ng;
        do_reset();
        #1;
        chk("rst_mem_en", {31'b0, mem_en_a}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we_a}, 32'd0);
        chk("rst_if_ack", {31'b0, if_ack_a}, 32'd0);
        chk("rst_dm_ack", {31'b0, dm_ack_a}, 32'd0);
        chk("rst_if_rdata", if_rdata_a, 32'd0);
        chk("rst_dm_rdata", dm_rdata_a, 32'd0);

        // single fetch read
        tick(); if_req_a = 1'b1; if_addr_a = 32'h10; #1;
        chk("f_en_T", {31'b0, mem_en_a}, 32'd1);
        chk("f_addr_T", mem_addr_a, 32'h10);
        chk("f_we_T", {31'b0, mem_we_a}, 32'd0);
        chk("f_stall_T", {31'b0, if_stall_a}, 32'd1);
        tick(); #1;
        chk("f_en_T1", {31'b0, mem_en_a}, 32'd0);
        chk("f_ack_T1", {31'b0, if_ack_a}, 32'd0);
        chk("f_stall_T1", {31'b0, if_stall_a}, 32'd1);
        tick(); #1;
        chk("f_ack_T2", {31'b0, if_ack_a}, 32'd1);
        chk("f_rdata_T2", if_rdata_a, 32'h0050_0093);
        chk("f_stall_T2", {31'b0, if_stall_a}, 32'd0);
        tick(); if_req_a = 1'b0; #1;
        chk("f_ack_T3", {31'b0, if_ack_a}, 32'd0);
        chk("f_rdata_hold", if_rdata_a, 32'h0050_0093);

        // data write
        tick(); dm_req_a = 1'b1; dm_we_a = 1'b1; dm_addr_a = 32'h100; dm_wdata_a = 32'hDEAD_BEEF; #1;
        chk("w_en", {31'b0, mem_en_a}, 32'd1);
        chk("w_we", {31'b0, mem_we_a}, 32'd1);
        chk("w_addr", mem_addr_a, 32'h100);
        chk("w_wdata", mem_wdata_a, 32'hDEAD_BEEF);
        chk("w_stall_T", {31'b0, dm_stall_a}, 32'd1);
        tick(); #1;
        chk("w_ack_T1", {31'b0, dm_ack_a}, 32'd1);
        chk("w_rdata_keep", dm_rdata_a, 32'd0);
        chk("w_stall_T1", {31'b0, dm_stall_a}, 32'd0);
        tick(); dm_req_a = 1'b0; dm_we_a = 1'b0; #1;
        chk("w_ack_T2", {31'b0, dm_ack_a}, 32'd0);
        chk("w_rdata_after", dm_rdata_a, 32'd0);

        // simultaneous requests from reset: data first
        do_reset();
        if_req_a = 1'b1; if_addr_a = 32'h10;
        dm_req_a = 1'b1; dm_we_a = 1'b0; dm_addr_a = 32'h100; #1;
        chk("s_addr_T", mem_addr_a, 32'h100);
        chk("s_we_T", {31'b0, mem_we_a}, 32'd0);
        tick(); tick(); #1;
        chk("s_dm_ack", {31'b0, dm_ack_a}, 32'd1);
        chk("s_dm_rdata", dm_rdata_a, 32'hDEAD_BEEF);
        chk("s_if_ack_T2", {31'b0, if_ack_a}, 32'd0);
        chk("s_if_stall_T2", {31'b0, if_stall_a}, 32'd1);
        tick(); dm_req_a = 1'b0; #1;
        chk("s_fetch_en_T3", {31'b0, mem_en_a}, 32'd1);
        chk("s_fetch_addr_T3", mem_addr_a, 32'h10);
        tick(); tick(); #1;
        chk("s_if_ack_T5", {31'b0, if_ack_a}, 32'd1);
        chk("s_if_rdata_T5", if_rdata_a, 32'h0050_0093);
        chk("s_dm_rdata_hold", dm_rdata_a, 32'hDEAD_BEEF);
        tick(); if_req_a = 1'b0;

        // starvation bound: expected grants D D D D F D D D D F
        do_reset();
        if_req_a = 1'b1; if_addr_a = 32'h10;
        dm_req_a = 1'b1; dm_we_a = 1'b0; dm_addr_a = 32'h100;
        ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            #1;
            if (mem_en_a) begin
                chk($sformatf("starve_grant%0d", ng), mem_addr_a, (ng % 5 == 4) ? 32'h10 : 32'h100);
                ng++;
            end
            tick();
        end
        chk("starve_count", ng, 32'd10);
        if_req_a = 1'b0; dm_req_a = 1'b0;

        // reset in the middle of a fetch read
        do_reset();
        if_req_a = 1'b1; if_addr_a = 32'h10; #1;
        chk("r_en_T", {31'b0, mem_en_a}, 32'd1);
        tick(); rst = 1'b1; #1;
        chk("r_ack_T1", {31'b0, if_ack_a}, 32'd0);
        tick(); rst = 1'b0; if_req_a = 1'b0; #1;
        chk("r_ack_T2", {31'b0, if_ack_a}, 32'd0);
        chk("r_en_T2", {31'b0, mem_en_a}, 32'd0);
        chk("r_rdata_T2", if_rdata_a, 32'd0);
        tick(); if_req_a = 1'b1; if_addr_a = 32'h4; #1;
        chk("r_en_T3", {31'b0, mem_en_a}, 32'd1);
        chk("r_addr_T3", mem_addr_a, 32'h4);
        tick(); tick(); #1;
        chk("r_ack_T5", {31'b0, if_ack_a}, 32'd1);
        chk("r_rdata_T5", if_rdata_a, 32'h1000_0004);
        tick(); if_req_a = 1'b0;

        // LATENCY=1 back-to-back fetches
        tick(); if_req_b = 1'b1; if_addr_b = 32'h0; #1;
        chk("l1_en_T", {31'b0, mem_en_b}, 32'd1);
        chk("l1_addr_T", mem_addr_b, 32'h0);
        tick(); #1;
        chk("l1_ack_T1", {31'b0, if_ack_b}, 32'd1);
        chk("l1_rdata_T1", if_rdata_b, 32'h1000_0000);
        chk("l1_en_T1", {31'b0, mem_en_b}, 32'd0);
        tick(); if_addr_b = 32'h4; #1;
        chk("l1_en_T2", {31'b0, mem_en_b}, 32'd1);
        chk("l1_addr_T2", mem_addr_b, 32'h4);
        chk("l1_ack_T2", {31'b0, if_ack_b}, 32'd0);
        tick(); #1;
        chk("l1_ack_T3", {31'b0, if_ack_b}, 32'd1);
        chk("l1_rdata_T3", if_rdata_b, 32'h1000_0004);
        tick(); if_req_b = 1'b0; #1;
        chk("l1_rdata_hold", if_rdata_b, 32'h1000_0004);
        chk("l1_ack_T4", {31'b0, if_ack_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
